// File: rtl/dino_jump_controller.sv
// Vertical motion sequencer for the T-Rex sprite: launch, variable-height rise,
// gravity fall with terminal speed, landing, duck and death freeze.
//
// state  | meaning
// GROUND | standing, DinoY tracks GroundY
// RISE   | moving up, vy > 0
// FALL   | moving down, fallV grows toward VMAX
// DUCK   | crouched on ground, DinoY tracks GroundY
// DEAD   | frozen until reset
module dino_jump_controller #(
    parameter int V0       = 12,
    parameter int G        = 1,
    parameter int MAX_HOLD = 6,
    parameter int FAST_G   = 3,
    parameter int VMAX     = 16
) (
    input  logic        animationClk,
    input  logic        rst,
    input  logic        step,
    input  logic        jump,
    input  logic        duck,
    input  logic        dead,
    input  logic [31:0] GroundY,
    output logic [31:0] DinoY,
    output logic        Airborne,
    output logic        onGround,
    output logic        isDuck,
    output logic        isDead,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        GROUND = 3'd0,
        RISE   = 3'd1,
        FALL   = 3'd2,
        DUCK   = 3'd3,
        DEAD   = 3'd4
    } state_t;

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic signed [11:0] V0_S   = 12'(V0);
    localparam logic signed [11:0] G_S    = 12'(G);
    localparam logic signed [11:0] FAST_S = 12'(FAST_G * G);
    localparam logic signed [11:0] VMAX_S = 12'(VMAX);

    state_t                state_q, state_d;
    logic [31:0]           dino_y_q, dino_y_d;
    logic signed [11:0]    vy_q, vy_d;
    logic signed [11:0]    fall_v_q, fall_v_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                  jump_pend_q, jump_pend_d;
    logic                  jump_q;

    logic                  jump_edge;
    logic                  launch_req;
    logic [31:0]           launch_y;
    logic signed [11:0]    grav;
    logic signed [11:0]    rise_vy;
    logic signed [11:0]    fall_sum;
    logic signed [11:0]    fall_f;
    logic [32:0]           fall_y;

    // State, position and velocity registers; jump_q always samples so a
    // button held through reset does not look like a fresh press.
    always_ff @(posedge animationClk) begin
        jump_q <= jump;
        if (rst) begin
            state_q     <= GROUND;
            dino_y_q    <= GroundY;
            vy_q        <= '0;
            fall_v_q    <= '0;
            hold_cnt_q  <= '0;
            jump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dino_y_q    <= dino_y_d;
            vy_q        <= vy_d;
            fall_v_q    <= fall_v_d;
            hold_cnt_q  <= hold_cnt_d;
            jump_pend_q <= jump_pend_d;
        end
    end

    // Physics datapath shared by the next-state logic.
    always_comb begin
        jump_edge  = jump & ~jump_q;
        launch_req = jump_pend_q | jump_edge;
        launch_y   = (GroundY >= 32'(V0)) ? GroundY - 32'(V0) : '0;
        grav       = duck ? FAST_S : G_S;
        rise_vy    = vy_q - grav;
        fall_sum   = fall_v_q + grav;
        fall_f     = (fall_sum > VMAX_S) ? VMAX_S : fall_sum;
        fall_y     = {1'b0, dino_y_q} + {21'b0, fall_f[10:0]};
    end

    // Next-state logic: motion advances only on step, death is immediate.
    always_comb begin
        state_d     = state_q;
        dino_y_d    = dino_y_q;
        vy_d        = vy_q;
        fall_v_d    = fall_v_q;
        hold_cnt_d  = hold_cnt_q;
        jump_pend_d = jump_pend_q | jump_edge;

        case (state_q)
            GROUND, DUCK: begin
                dino_y_d = GroundY;
                if (step) begin
                    if (launch_req) begin
                        state_d     = RISE;
                        dino_y_d    = launch_y;
                        vy_d        = V0_S - G_S;
                        hold_cnt_d  = '0;
                        jump_pend_d = 1'b0;
                    end else if (state_q == GROUND && duck) begin
                        state_d = DUCK;
                    end else if (state_q == DUCK && !duck) begin
                        state_d = GROUND;
                    end
                end
            end
            RISE: begin
                jump_pend_d = 1'b0;
                if (step) begin
                    if ({20'b0, vy_q} > dino_y_q) begin
                        dino_y_d = '0;
                        state_d  = FALL;
                        fall_v_d = '0;
                    end else begin
                        dino_y_d = dino_y_q - {20'b0, vy_q};
                        if (jump && !duck && hold_cnt_q < HW'(MAX_HOLD)) begin
                            hold_cnt_d = hold_cnt_q + HW'(1);
                        end else begin
                            vy_d = rise_vy;
                            if (rise_vy <= 12'sd0) begin
                                state_d  = FALL;
                                fall_v_d = '0;
                            end
                        end
                    end
                end
            end
            FALL: begin
                jump_pend_d = 1'b0;
                if (step) begin
                    fall_v_d = fall_f;
                    if (fall_y >= {1'b0, GroundY}) begin
                        dino_y_d = GroundY;
                        fall_v_d = '0;
                        state_d  = duck ? DUCK : GROUND;
                    end else begin
                        dino_y_d = fall_y[31:0];
                    end
                end
            end
            DEAD: begin
                jump_pend_d = 1'b0;
            end
            default: begin
                state_d = GROUND;
            end
        endcase

        if (dead) begin
            state_d     = DEAD;
            dino_y_d    = dino_y_q;
            vy_d        = vy_q;
            fall_v_d    = fall_v_q;
            hold_cnt_d  = hold_cnt_q;
            jump_pend_d = 1'b0;
        end
    end

    // Status decoded purely from registered state.
    always_comb begin
        DinoY    = dino_y_q;
        state    = state_q;
        Airborne = (state_q == RISE) || (state_q == FALL);
        onGround = (state_q == GROUND) || (state_q == DUCK);
        isDuck   = (state_q == DUCK);
        isDead   = (state_q == DEAD);
    end

endmodule
